// File: rtl/dgldpc_sched_pkg.sv
// Shared helpers for the VNU conversion scheduler: ID width function,
// default configuration, pointer type and the most-negative message constant.
package dgldpc_sched_pkg;

    // Index width that never collapses to zero bits, even for tiny requester counts.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DATA_W_DFLT  = 8;
    localparam int NUM_REQ_DFLT = 4;
    localparam int CNT_W_DFLT   = 16;
    localparam int ID_W_DFLT    = clog2_min1(NUM_REQ_DFLT);

    typedef logic [ID_W_DFLT-1:0] rr_ptr_t;

    localparam logic [DATA_W_DFLT-1:0] MOST_NEG_DFLT = {1'b1, {(DATA_W_DFLT-1){1'b0}}};

endpackage

// File: rtl/conv_compl2sm.sv
// Two's-complement to sign-magnitude converter; the most negative input has
// no magnitude representation and saturates to all ones.
module conv_compl2sm #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data
);

    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W-1:0] neg_data;

    assign neg_data = ~i_data + DATA_W'(1);

    always_comb begin
        // NOTE: every branch assigns o_data, and the default comes first, so no latch can be inferred.
        o_data = i_data;
        if (i_data == MOST_NEG) begin
            o_data = '1;
        end else if (i_data[DATA_W-1]) begin
            o_data = {1'b1, neg_data[DATA_W-2:0]};
        end
    end

endmodule

// File: rtl/vnu_conv_rr_sched.sv
// Round-robin scheduler sharing one sign-magnitude converter between VNU
// producers, with a single registered output stage and a saturation counter.
module vnu_conv_rr_sched
    import dgldpc_sched_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DFLT,
    parameter int NUM_REQ = NUM_REQ_DFLT,
    parameter int CNT_W   = CNT_W_DFLT,
    localparam int ID_W   = clog2_min1(NUM_REQ)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic                      o_valid,
    output logic [DATA_W-1:0]         o_data,
    output logic [ID_W-1:0]           o_id,
    input  logic                      i_ready,
    input  logic                      i_clr_cnt,
    output logic [CNT_W-1:0]          o_sat_cnt
);

    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [ID_W-1:0]   LAST_ID  = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0]      rr_ptr;
    logic [2*NUM_REQ-1:0] req_dbl;
    logic [2*NUM_REQ-1:0] req_rot;
    logic                 grant_found;
    logic [ID_W-1:0]      grant_idx;
    logic                 stage_free;
    logic                 xfer;
    logic [DATA_W-1:0]    grant_data;
    logic [DATA_W-1:0]    conv_data;
    logic                 grant_sat;

    // Rotating a doubled request vector puts rr_ptr at bit 0, so a plain
    // lowest-bit search yields the round-robin winner without wrap logic.
    always_comb begin
        req_dbl     = {i_req_valid, i_req_valid};
        req_rot     = req_dbl >> rr_ptr;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'((int'(rr_ptr) + j) % NUM_REQ);
            end
        end
    end

    assign stage_free = !o_valid || i_ready;
    // Reset gates the handshake so no producer believes a word was taken.
    assign xfer       = grant_found && stage_free && i_rst_n;

    always_comb begin
        o_req_ready = '0;
        if (xfer) begin
            o_req_ready[grant_idx] = 1'b1;
        end
    end

    assign grant_data = i_req_data[grant_idx*DATA_W +: DATA_W];
    assign grant_sat  = (grant_data == MOST_NEG);

    conv_compl2sm #(
        .DATA_W(DATA_W)
    ) u_conv (
        .i_data(grant_data),
        .o_data(conv_data)
    );

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_id    <= '0;
            rr_ptr  <= '0;
        end else if (xfer) begin
            o_valid <= 1'b1;
            o_data  <= conv_data;
            o_id    <= grant_idx;
            rr_ptr  <= (grant_idx == LAST_ID) ? '0 : grant_idx + ID_W'(1);
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end

    // Clear wins over a same-cycle increment; the count sticks at its maximum.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr_cnt) begin
            o_sat_cnt <= '0;
        end else if (xfer && grant_sat && (o_sat_cnt != CNT_MAX)) begin
            o_sat_cnt <= o_sat_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_vnu_conv_rr_sched.sv
// Directed self-checking bench for vnu_conv_rr_sched (DATA_W=8, NUM_REQ=4, CNT_W=4).
module tb_vnu_conv_rr_sched;

    logic        i_clk;
    logic        i_rst_n;
    logic [3:0]  i_req_valid;
    logic [31:0] i_req_data;
    logic [3:0]  o_req_ready;
    logic        o_valid;
    logic [7:0]  o_data;
    logic [1:0]  o_id;
    logic        i_ready;
    logic        i_clr_cnt;
    logic [3:0]  o_sat_cnt;

    int checks = 0;
    int errors = 0;

    vnu_conv_rr_sched #(
        .DATA_W (8),
        .NUM_REQ(4),
        .CNT_W  (4)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_req_valid(i_req_valid),
        .i_req_data (i_req_data),
        .o_req_ready(o_req_ready),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .o_id       (o_id),
        .i_ready    (i_ready),
        .i_clr_cnt  (i_clr_cnt),
        .o_sat_cnt  (o_sat_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        i_req_valid = 4'b1111;
        i_req_data  = 32'h04030201;
        i_ready     = 1'b1;
        i_rst_n     = 1'b0;
        #1;
        checks++;
        if (o_req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready: got %b want 0000", o_req_ready);
        end
        tick();
        checks++;
        if (o_valid !== 1'b0 || o_data !== 8'h00 || o_id !== 2'd0 || o_sat_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: got v=%b d=%h id=%0d cnt=%0d want v=0 d=00 id=0 cnt=0",
                     o_valid, o_data, o_id, o_sat_cnt);
        end
        i_req_valid = 4'b0000;
        i_rst_n     = 1'b1;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        i_ready          = 1'b1;
        i_req_valid      = 4'b0001;
        i_req_data[7:0]  = 8'hFD;
        #1;
        checks++;
        if (o_req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL single_ready0: got %b want 0001", o_req_ready);
        end
        tick();
        i_req_valid        = 4'b0100;
        i_req_data[23:16]  = 8'h05;
        checks++;
        if (o_valid !== 1'b1 || o_data !== 8'h83 || o_id !== 2'd0) begin
            errors++;
            $display("FAIL single_req0: got v=%b d=%h id=%0d want v=1 d=83 id=0", o_valid, o_data, o_id);
        end
        #1;
        checks++;
        if (o_req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_ready2: got %b want 0100", o_req_ready);
        end
        tick();
        i_req_valid = 4'b0000;
        checks++;
        if (o_valid !== 1'b1 || o_data !== 8'h05 || o_id !== 2'd2) begin
            errors++;
            $display("FAIL single_req2: got v=%b d=%h id=%0d want v=1 d=05 id=2", o_valid, o_data, o_id);
        end
        tick();
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: got v=%b want v=0", o_valid);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        i_req_data  = 32'h04030201;
        i_req_valid = 4'b1111;
        i_ready     = 1'b1;
        #1;
        checks++;
        if (o_req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL rr_first_ready: got %b want 0001", o_req_ready);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (o_valid !== 1'b1 || o_id !== 2'(i % 4) || o_data !== 8'(i % 4 + 1)) begin
                errors++;
                $display("FAIL rr_seq[%0d]: got v=%b id=%0d d=%h want v=1 id=%0d d=%h",
                         i, o_valid, o_id, o_data, i % 4, i % 4 + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        // Continues from round-robin: output holds id 1 (data 02), pointer at 2.
        i_ready = 1'b0;
        #1;
        checks++;
        if (o_req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL bp_ready_drop: got %b want 0000", o_req_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (o_valid !== 1'b1 || o_id !== 2'd1 || o_data !== 8'h02 || o_req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v=%b id=%0d d=%h rdy=%b want v=1 id=1 d=02 rdy=0000",
                         i, o_valid, o_id, o_data, o_req_ready);
            end
        end
        i_ready = 1'b1;
        #1;
        checks++;
        if (o_req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL bp_release_ready: got %b want 0100", o_req_ready);
        end
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_id !== 2'd2 || o_data !== 8'h03) begin
            errors++;
            $display("FAIL bp_release: got v=%b id=%0d d=%h want v=1 id=2 d=03", o_valid, o_id, o_data);
        end
        i_req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_saturation();
        logic [3:0] exp_cnt;
        do_reset();
        i_req_data  = 32'h80808080;
        i_req_valid = 4'b0001;
        i_ready     = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            exp_cnt = (n < 15) ? 4'(n) : 4'd15;
            checks++;
            if (o_valid !== 1'b1 || o_data !== 8'hFF || o_sat_cnt !== exp_cnt) begin
                errors++;
                $display("FAIL sat[%0d]: got v=%b d=%h cnt=%0d want v=1 d=ff cnt=%0d",
                         n, o_valid, o_data, o_sat_cnt, exp_cnt);
            end
        end
        i_clr_cnt = 1'b1;
        tick();
        i_clr_cnt = 1'b0;
        checks++;
        if (o_data !== 8'hFF || o_sat_cnt !== 4'd0) begin
            errors++;
            $display("FAIL sat_clr_priority: got d=%h cnt=%0d want d=ff cnt=0", o_data, o_sat_cnt);
        end
        tick();
        i_req_valid = 4'b0000;
        checks++;
        if (o_sat_cnt !== 4'd1) begin
            errors++;
            $display("FAIL sat_after_clr: got cnt=%0d want 1", o_sat_cnt);
        end
        tick();
    endtask

    task automatic test_wrap_sparse();
        do_reset();
        i_ready     = 1'b1;
        i_req_data  = 32'h7F00FF00;
        i_req_valid = 4'b0010;
        tick();
        checks++;
        if (o_id !== 2'd1 || o_data !== 8'h81) begin
            errors++;
            $display("FAIL wrap_setup: got id=%0d d=%h want id=1 d=81", o_id, o_data);
        end
        i_req_valid = 4'b1010;
        #1;
        checks++;
        if (o_req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_ready3a: got %b want 1000", o_req_ready);
        end
        tick();
        checks++;
        if (o_id !== 2'd3 || o_data !== 8'h7F || o_req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL wrap_grant3a: got id=%0d d=%h rdy=%b want id=3 d=7f rdy=0010",
                     o_id, o_data, o_req_ready);
        end
        tick();
        checks++;
        if (o_id !== 2'd1 || o_data !== 8'h81 || o_req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_grant1: got id=%0d d=%h rdy=%b want id=1 d=81 rdy=1000",
                     o_id, o_data, o_req_ready);
        end
        tick();
        i_req_valid = 4'b0000;
        checks++;
        if (o_id !== 2'd3 || o_data !== 8'h7F) begin
            errors++;
            $display("FAIL wrap_grant3b: got id=%0d d=%h want id=3 d=7f", o_id, o_data);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        // Pointer sits at 0 after the wrap test.
        i_ready     = 1'b1;
        i_req_data  = 32'h00000580;
        i_req_valid = 4'b0001;
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_sat_cnt !== 4'd1 || o_data !== 8'hFF) begin
            errors++;
            $display("FAIL rstmid_setup: got v=%b cnt=%0d d=%h want v=1 cnt=1 d=ff",
                     o_valid, o_sat_cnt, o_data);
        end
        i_req_valid = 4'b0110;
        i_rst_n     = 1'b0;
        #1;
        checks++;
        if (o_req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL rstmid_ready: got %b want 0000", o_req_ready);
        end
        tick();
        checks++;
        if (o_valid !== 1'b0 || o_sat_cnt !== 4'd0 || o_data !== 8'h00 || o_id !== 2'd0) begin
            errors++;
            $display("FAIL rstmid_state: got v=%b cnt=%0d d=%h id=%0d want v=0 cnt=0 d=00 id=0",
                     o_valid, o_sat_cnt, o_data, o_id);
        end
        i_rst_n = 1'b1;
        #1;
        checks++;
        if (o_req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL rstmid_first_ready: got %b want 0010", o_req_ready);
        end
        tick();
        i_req_valid = 4'b0000;
        checks++;
        if (o_valid !== 1'b1 || o_id !== 2'd1 || o_data !== 8'h05) begin
            errors++;
            $display("FAIL rstmid_first_grant: got v=%b id=%0d d=%h want v=1 id=1 d=05",
                     o_valid, o_id, o_data);
        end
        tick();
    endtask

    initial begin
        i_rst_n     = 1'b0;
        i_req_valid = 4'b0000;
        i_req_data  = 32'h0;
        i_ready     = 1'b0;
        i_clr_cnt   = 1'b0;

        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_saturation();
        test_wrap_sparse();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
